// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-side TX controller slice.
// Provides the controller state encoding, the serializer phase encoding,
// the command codes coming from the RX frame decoder and a helper that
// sizes the result word counter.
package sys_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_ALU_WAIT,
    ST_TX_SEND,
    ST_TX_DRAIN
  } sys_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SEND,
    PH_DRAIN
  } tx_phase_e;

  localparam logic [2:0] CMD_WRITE = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_ALU   = 3'b100;

  // Width of a counter that must hold the value 'words' itself.
  function automatic int unsigned word_cnt_width(input int unsigned words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_serializer.sv
// Result serializer: holds a multi-word result and hands it to the UART TX
// one DATA_WIDTH word at a time, least-significant word first.
// Ports:
//   TXCont_CLK / TXCont_RST  clock, asynchronous active-low reset
//   load, load_words, load_data  capture a new result (pulse)
//   abort        discard the result and drop TX_Valid
//   tx_busy      UART TX busy
//   tx_valid, tx_data  registered word towards the UART TX
//   accepted     this cycle the UART takes the presented word
//   drained      this cycle the UART finished the frame in flight
//   done         drained on the last word of the result
module sys_ctrl_tx_serializer
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ALU_WORDS  = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic                            TXCont_CLK,
  input  logic                            TXCont_RST,
  input  logic                            load,
  input  logic [CNT_W-1:0]                load_words,
  input  logic [ALU_WORDS*DATA_WIDTH-1:0] load_data,
  input  logic                            abort,
  input  logic                            tx_busy,
  output logic                            tx_valid,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            accepted,
  output logic                            drained,
  output logic                            done
);

  localparam int unsigned RW = ALU_WORDS * DATA_WIDTH;

  tx_phase_e        phase_q;
  logic [RW-1:0]    res_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RW-1:0]    res_shift;

  assign res_shift = res_q >> DATA_WIDTH;
  assign accepted  = (phase_q == PH_SEND) && tx_busy;
  assign drained   = (phase_q == PH_DRAIN) && !tx_busy;
  assign done      = drained && (cnt_q == CNT_W'(1));

  always_ff @(posedge TXCont_CLK or negedge TXCont_RST) begin
    if (!TXCont_RST) begin
      phase_q  <= PH_IDLE;
      res_q    <= '0;
      cnt_q    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (abort) begin
      phase_q  <= PH_IDLE;
      res_q    <= '0;
      cnt_q    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      phase_q  <= PH_SEND;
      res_q    <= load_data;
      cnt_q    <= load_words;
      tx_valid <= 1'b1;
      tx_data  <= load_data[DATA_WIDTH-1:0];
    end else if (accepted) begin
      phase_q  <= PH_DRAIN;
      tx_valid <= 1'b0;
    end else if (drained) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (done) begin
        phase_q <= PH_IDLE;
        res_q   <= '0;
        tx_data <= '0;
      end else begin
        // Next word is presented in the same edge that retires the previous one.
        phase_q  <= PH_SEND;
        res_q    <= res_shift;
        tx_valid <= 1'b1;
        tx_data  <= res_shift[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/sys_ctrl_tx_engine.sv
// System-side TX controller: accepts decoded commands (register write,
// register read, ALU operation), drives the register file and ALU, and
// streams results to the UART TX via sys_ctrl_tx_serializer.
// All outputs except SCtl_Cmd_Ready are registered.
// Ports:
//   SCtl_CLK, SCtl_RST                 clock, asynchronous active-low reset
//   SCtl_Cmd_Valid/Cmd/Addr/Pdata      command from the RX frame decoder
//   SCtl_Cmd_Ready                     high only in IDLE
//   SCtl_RF_Addr/RF_WrData/Wr_En/Rd_En register file request side
//   SCtl_RF_RdData/RF_Valid            register file response
//   SCtl_ALU_En/ALU_Fun/CLK_En         ALU control and clock-gate enable
//   SCtl_ALU_Out/ALU_Valid             ALU result
//   SCtl_TX_Data/TX_Valid/TX_Busy      UART TX handshake
//   SCtl_Err                           one-cycle error pulse
module sys_ctrl_tx_engine
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned ALU_WORDS  = 2,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned TO_W       = 11
) (
  input  logic                            SCtl_CLK,
  input  logic                            SCtl_RST,
  input  logic                            SCtl_Cmd_Valid,
  input  logic [2:0]                      SCtl_Cmd,
  input  logic [ADDR_WIDTH-1:0]           SCtl_Addr,
  input  logic [DATA_WIDTH-1:0]           SCtl_Pdata,
  output logic                            SCtl_Cmd_Ready,
  output logic [ADDR_WIDTH-1:0]           SCtl_RF_Addr,
  output logic [DATA_WIDTH-1:0]           SCtl_RF_WrData,
  output logic                            SCtl_Wr_En,
  output logic                            SCtl_Rd_En,
  input  logic [DATA_WIDTH-1:0]           SCtl_RF_RdData,
  input  logic                            SCtl_RF_Valid,
  output logic                            SCtl_ALU_En,
  output logic [FUN_WIDTH-1:0]            SCtl_ALU_Fun,
  output logic                            SCtl_CLK_En,
  input  logic [ALU_WORDS*DATA_WIDTH-1:0] SCtl_ALU_Out,
  input  logic                            SCtl_ALU_Valid,
  output logic [DATA_WIDTH-1:0]           SCtl_TX_Data,
  output logic                            SCtl_TX_Valid,
  input  logic                            SCtl_TX_Busy,
  output logic                            SCtl_Err
);

  localparam int unsigned RW    = ALU_WORDS * DATA_WIDTH;
  localparam int unsigned CNT_W = word_cnt_width(ALU_WORDS);

  sys_state_e       state_q, state_d;
  logic [TO_W-1:0]  to_q;
  logic             expired;
  logic             err_d, load, abort;
  logic [CNT_W-1:0] load_words;
  logic [RW-1:0]    load_data;
  logic             ser_accepted, ser_drained, ser_done;

  logic                  wr_en_d, rd_en_d, alu_en_d, clk_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wrdata_d;
  logic [FUN_WIDTH-1:0]  alu_fun_d;

  assign SCtl_Cmd_Ready = (state_q == ST_IDLE);
  assign expired        = (TIMEOUT != 0) && (to_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge SCtl_CLK or negedge SCtl_RST) begin
    if (!SCtl_RST) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    load       = 1'b0;
    load_words = '0;
    load_data  = '0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (SCtl_Cmd_Valid) begin
          case (SCtl_Cmd)
            CMD_WRITE: state_d = ST_WRITE;
            CMD_READ:  state_d = ST_READ_WAIT;
            CMD_ALU:   state_d = ST_ALU_WAIT;
            default:   err_d   = 1'b1;
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ_WAIT: begin
        if (SCtl_RF_Valid) begin
          state_d                   = ST_TX_SEND;
          load                      = 1'b1;
          load_words                = CNT_W'(1);
          load_data[DATA_WIDTH-1:0] = SCtl_RF_RdData;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          abort   = 1'b1;
        end
      end
      ST_ALU_WAIT: begin
        if (SCtl_ALU_Valid) begin
          state_d    = ST_TX_SEND;
          load       = 1'b1;
          load_words = CNT_W'(ALU_WORDS);
          load_data  = SCtl_ALU_Out;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          abort   = 1'b1;
        end
      end
      ST_TX_SEND: begin
        if (ser_accepted) begin
          state_d = ST_TX_DRAIN;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          abort   = 1'b1;
        end
      end
      ST_TX_DRAIN: begin
        if (ser_drained) begin
          state_d = ser_done ? ST_IDLE : ST_TX_SEND;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          abort   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Any state change restarts the wait budget, including TX_DRAIN -> TX_SEND.
  always_ff @(posedge SCtl_CLK or negedge SCtl_RST) begin
    if (!SCtl_RST) begin
      to_q <= '0;
    end else if (state_d != state_q) begin
      to_q <= '0;
    end else if (state_q inside {ST_READ_WAIT, ST_ALU_WAIT, ST_TX_SEND, ST_TX_DRAIN}) begin
      to_q <= to_q + TO_W'(1);
    end
  end

  // Next values of the registered outputs, decoded from the next state.
  // Command fields are taken from the inputs on the accept edge and then
  // held by feeding the registered outputs back.
  always_comb begin
    wr_en_d     = (state_d == ST_WRITE);
    rd_en_d     = (state_d == ST_READ_WAIT);
    alu_en_d    = (state_d == ST_ALU_WAIT);
    clk_en_d    = (state_d == ST_ALU_WAIT) ||
                  (SCtl_CLK_En && (state_d inside {ST_TX_SEND, ST_TX_DRAIN}));
    rf_addr_d   = '0;
    rf_wrdata_d = '0;
    alu_fun_d   = '0;
    if (state_d == ST_WRITE) begin
      rf_addr_d   = SCtl_Addr;
      rf_wrdata_d = SCtl_Pdata;
    end
    if (state_d == ST_READ_WAIT) begin
      rf_addr_d = (state_q == ST_IDLE) ? SCtl_Addr : SCtl_RF_Addr;
    end
    if (state_d == ST_ALU_WAIT) begin
      alu_fun_d = (state_q == ST_IDLE) ? SCtl_Pdata[FUN_WIDTH-1:0] : SCtl_ALU_Fun;
    end
  end

  always_ff @(posedge SCtl_CLK or negedge SCtl_RST) begin
    if (!SCtl_RST) begin
      SCtl_Wr_En     <= 1'b0;
      SCtl_Rd_En     <= 1'b0;
      SCtl_ALU_En    <= 1'b0;
      SCtl_CLK_En    <= 1'b0;
      SCtl_RF_Addr   <= '0;
      SCtl_RF_WrData <= '0;
      SCtl_ALU_Fun   <= '0;
      SCtl_Err       <= 1'b0;
    end else begin
      SCtl_Wr_En     <= wr_en_d;
      SCtl_Rd_En     <= rd_en_d;
      SCtl_ALU_En    <= alu_en_d;
      SCtl_CLK_En    <= clk_en_d;
      SCtl_RF_Addr   <= rf_addr_d;
      SCtl_RF_WrData <= rf_wrdata_d;
      SCtl_ALU_Fun   <= alu_fun_d;
      SCtl_Err       <= err_d;
    end
  end

  sys_ctrl_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ALU_WORDS  (ALU_WORDS),
    .CNT_W      (CNT_W)
  ) u_serializer (
    .TXCont_CLK (SCtl_CLK),
    .TXCont_RST (SCtl_RST),
    .load       (load),
    .load_words (load_words),
    .load_data  (load_data),
    .abort      (abort),
    .tx_busy    (SCtl_TX_Busy),
    .tx_valid   (SCtl_TX_Valid),
    .tx_data    (SCtl_TX_Data),
    .accepted   (ser_accepted),
    .drained    (ser_drained),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_sys_ctrl_tx_engine.sv
// Self-checking bench for sys_ctrl_tx_engine (4-word results, 16-cycle timeout).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sys_ctrl_tx_engine;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int FW  = 4;
  localparam int NW  = 4;
  localparam int TMO = 16;
  localparam int TOW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [2:0]      cmd = '0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   pdata = '0;
  logic            cmd_ready;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_wrdata;
  logic            wr_en, rd_en;
  logic [DW-1:0]   rf_rddata = '0;
  logic            rf_valid = 1'b0;
  logic            alu_en;
  logic [FW-1:0]   alu_fun;
  logic            clk_en;
  logic [NW*DW-1:0] alu_out = '0;
  logic            alu_valid = 1'b0;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_busy = 1'b0;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sys_ctrl_tx_engine #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FUN_WIDTH  (FW),
    .ALU_WORDS  (NW),
    .TIMEOUT    (TMO),
    .TO_W       (TOW)
  ) dut (
    .SCtl_CLK       (clk),
    .SCtl_RST       (rst_n),
    .SCtl_Cmd_Valid (cmd_valid),
    .SCtl_Cmd       (cmd),
    .SCtl_Addr      (addr),
    .SCtl_Pdata     (pdata),
    .SCtl_Cmd_Ready (cmd_ready),
    .SCtl_RF_Addr   (rf_addr),
    .SCtl_RF_WrData (rf_wrdata),
    .SCtl_Wr_En     (wr_en),
    .SCtl_Rd_En     (rd_en),
    .SCtl_RF_RdData (rf_rddata),
    .SCtl_RF_Valid  (rf_valid),
    .SCtl_ALU_En    (alu_en),
    .SCtl_ALU_Fun   (alu_fun),
    .SCtl_CLK_En    (clk_en),
    .SCtl_ALU_Out   (alu_out),
    .SCtl_ALU_Valid (alu_valid),
    .SCtl_TX_Data   (tx_data),
    .SCtl_TX_Valid  (tx_valid),
    .SCtl_TX_Busy   (tx_busy),
    .SCtl_Err       (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: word idx of a result, least-significant word first.
  function automatic logic [DW-1:0] exp_word(input logic [NW*DW-1:0] r, input int idx);
    return DW'(r >> (DW * idx));
  endfunction

  // Presents a command for one accept edge; returns at the first falling
  // edge after the accept, with the command fields scrambled.
  task automatic issue(input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] p);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd = c; addr = a; pdata = p;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = 3'($urandom); addr = AW'($urandom); pdata = DW'($urandom);
  endtask

  task automatic serve_tx(input int n, input logic [NW*DW-1:0] r, input logic alu);
    for (int w = 0; w < n; w++) begin
      int d = $urandom_range(0, 2);
      int h = $urandom_range(1, 4);
      check("tx_valid_up", tx_valid, 1);
      check("tx_word", tx_data, exp_word(r, w));
      check("clk_en_tx", clk_en, alu);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, exp_word(r, w));
      end
      tx_busy = 1'b1;
      for (int i = 0; i < h; i++) begin
        @(negedge clk);
        check("tx_valid_drop", tx_valid, 0);
      end
      tx_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic finish_txn();
    check("ready_after", cmd_ready, 1);
    check("tx_valid_after", tx_valid, 0);
    check("clk_en_after", clk_en, 0);
    check("err_after", err, 0);
    @(negedge clk);
    check("no_extra_word", tx_valid, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] p);
    issue(3'b001, a, p);
    check("wr_en_pulse", wr_en, 1);
    check("wr_addr", rf_addr, a);
    check("wr_data", rf_wrdata, p);
    check("wr_no_tx", tx_valid, 0);
    check("wr_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("wr_en_single", wr_en, 0);
    check("wr_ready_back", cmd_ready, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat, input logic poke);
    logic [NW*DW-1:0] r;
    r = '0;
    r[DW-1:0] = d;
    issue(3'b010, a, DW'($urandom));
    for (int i = 0; i < lat; i++) begin
      check("rd_en_wait", rd_en, 1);
      check("rd_addr_wait", rf_addr, a);
      check("rd_ready_low", cmd_ready, 0);
      if (poke && i == 0) begin
        cmd_valid = 1'b1; cmd = 3'b001;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("busy_cmd_ignored", wr_en, 0);
    end
    check("rd_en_final", rd_en, 1);
    check("rd_addr_final", rf_addr, a);
    rf_valid = 1'b1; rf_rddata = d;
    @(negedge clk);
    rf_valid = 1'b0; rf_rddata = DW'($urandom);
    check("rd_en_drop", rd_en, 0);
    serve_tx(1, r, 1'b0);
    finish_txn();
  endtask

  task automatic do_alu(input logic [DW-1:0] p, input logic [NW*DW-1:0] r, input int lat);
    issue(3'b100, AW'($urandom), p);
    for (int i = 0; i < lat; i++) begin
      check("alu_en_wait", alu_en, 1);
      check("alu_fun_wait", alu_fun, p[FW-1:0]);
      check("clk_en_wait", clk_en, 1);
      @(negedge clk);
    end
    check("alu_en_final", alu_en, 1);
    check("alu_fun_final", alu_fun, p[FW-1:0]);
    alu_valid = 1'b1; alu_out = r;
    @(negedge clk);
    alu_valid = 1'b0; alu_out = (NW*DW)'($urandom);
    check("alu_en_drop", alu_en, 0);
    serve_tx(NW, r, 1'b1);
    finish_txn();
  endtask

  task automatic do_illegal(input logic [2:0] c);
    issue(c, AW'($urandom), DW'($urandom));
    check("illegal_err", err, 1);
    check("illegal_ready", cmd_ready, 1);
    check("illegal_strobes", {wr_en, rd_en, alu_en, tx_valid}, 0);
    @(negedge clk);
    check("illegal_err_single", err, 0);
  endtask

  task automatic do_timeout();
    int first;
    first = -1;
    issue(3'b010, 8'h44, 8'h00);
    for (int k = 1; k <= 40; k++) begin
      if (err) begin
        first = k;
        break;
      end
      if (k == TMO) check("to_rd_en_before", rd_en, 1);
      @(negedge clk);
    end
    // Err becomes visible TIMEOUT cycles after the READ_WAIT entry edge.
    check("timeout_cycle", first, TMO + 1);
    check("to_rd_en_drop", rd_en, 0);
    check("to_ready", cmd_ready, 1);
    check("to_no_tx", tx_valid, 0);
    @(negedge clk);
    check("to_err_single", err, 0);
  endtask

  task automatic do_reset_midrun();
    logic seen;
    logic [NW*DW-1:0] r;
    r = 32'hC3A5_1234;
    issue(3'b100, 8'h00, 8'h02);
    check("rst_alu_fun", alu_fun, 4'h2);
    alu_valid = 1'b1; alu_out = r;
    @(negedge clk);
    alu_valid = 1'b0;
    check("rst_word0", tx_data, 8'h34);
    tx_busy = 1'b1;
    @(negedge clk);
    check("rst_in_drain", tx_valid, 0);
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", {wr_en, rd_en, alu_en, clk_en, tx_valid, err}, 0);
    check("rst_tx_data_zero", tx_data, 0);
    check("rst_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tx_busy = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid) seen = 1'b1;
    end
    check("rst_tail_discarded", seen, 0);
    check("rst_ready_after", cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] illegal_codes [5];
    illegal_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    repeat (3) @(negedge clk);
    check("reset_ready", cmd_ready, 1);
    check("reset_strobes", {wr_en, rd_en, alu_en, clk_en, tx_valid, err}, 0);
    check("reset_rf_addr", rf_addr, 0);
    check("reset_tx_data", tx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_write(8'h05, 8'hA5);
    do_read(8'h03, 8'h3C, 3, 1'b0);
    do_alu(8'h02, 32'h0000_1234, 2);
    do_alu(8'h07, 32'hDEAD_BEEF, 4);
    do_timeout();
    do_reset_midrun();
    do_illegal(3'b111);
    do_read(8'h81, 8'h5A, 4, 1'b1);

    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 9);
      if (kind <= 2)
        do_write(AW'($urandom), DW'($urandom));
      else if (kind <= 5)
        do_read(AW'($urandom), DW'($urandom), $urandom_range(0, 6), 1'($urandom));
      else if (kind <= 8)
        do_alu(DW'($urandom), (NW*DW)'($urandom), $urandom_range(0, 6));
      else
        do_illegal(illegal_codes[$urandom_range(0, 4)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
